// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory responder: funct3 access sizes,
// FSM states and the word-index width helper.
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte/half merge into the old word and
// load lane select with sign/zero extension. Unsupported funct3 acts as word.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half lane uses only addr_lo[1], so odd half addresses are force-aligned.
  assign byte_off = {addr_lo, 3'b000};
  assign half_off = {addr_lo[1], 4'b0000};
  assign byte_sel = old_word[byte_off +: 8];
  assign half_sel = old_word[half_off +: 16];

  always_comb begin
    merged    = old_word;
    load_data = old_word;
    case (funct3)
      F3_B, F3_BU: begin
        merged[byte_off +: 8] = wdata[7:0];
        load_data = funct3[2] ? {24'h000000, byte_sel}
                              : {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H, F3_HU: begin
        merged[half_off +: 16] = wdata[15:0];
        load_data = funct3[2] ? {16'h0000, half_sel}
                              : {{16{half_sel[15]}}, half_sel};
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory responder with stall handshake (IDLE->WAIT->DONE).
// Optional macro MISALIGN_CHECK_EN flags misaligned half/word accesses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign_err
);

  localparam int unsigned AW = idx_width(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          req;
  logic          commit;
  logic          mis_hit;
  logic [AW-1:0] word_idx;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [31:0]   load_data;
  logic          unused_addr;
  logic [31:0]   mem [DEPTH];

  assign req         = mem_read_en | mem_write_en;
  assign word_idx    = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];
  assign old_word    = mem[word_idx];

`ifdef MISALIGN_CHECK_EN
  logic is_byte, is_half;
  assign is_byte = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_half = (funct3 == F3_H) || (funct3 == F3_HU);
  assign mis_hit = (is_half && addr[0]) ||
                   (!is_byte && !is_half && (addr[1:0] != 2'b00));
`else
  assign mis_hit = 1'b0;
`endif

  dmem_lane_align u_lane (
    .funct3    (funct3),
    .addr_lo   (addr[1:0]),
    .wdata     (wdata),
    .old_word  (old_word),
    .merged    (merged),
    .load_data (load_data)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          stall     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A store wins when both enables are high, so rdata is left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rdata        <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      misalign_err <= commit & mis_hit;
      if (state == IDLE && req) begin
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && !mem_write_en) begin
        rdata <= mis_hit ? '0 : load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && mem_write_en && !mis_hit) begin
      mem[word_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl against a byte-addressed reference model.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;
`ifdef MISALIGN_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign_err;

  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  bit [7:0]    mb [DEPTH*4];
  logic [31:0] exp_rdata = '0;
  logic        exp_stall = 1'b0;
  logic        exp_mis = 1'b0;
  int          n_pass = 0;
  int          n_tot = 0;
  int          lit_req = 0;
  int          lit_done = 0;
  logic [31:0] lit_exp = '0;
  string       lit_name = "";
  bit          run = 1'b1;

  function automatic int unsigned acc_size(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [2:0] f, input logic [31:0] a);
    return MCHK && ((a % acc_size(f)) != 0);
  endfunction

  function automatic int unsigned base_of(input logic [2:0] f, input logic [31:0] a);
    int unsigned b;
    b = a % (DEPTH * 4);
    return b - (b % acc_size(f));
  endfunction

  task automatic m_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int unsigned b;
    b = base_of(f, a);
    for (int i = 0; i < int'(acc_size(f)); i++) mb[b + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a);
    int unsigned b;
    logic [31:0] v;
    b = base_of(f, a);
    v = '0;
    for (int i = 0; i < int'(acc_size(f)); i++) v = v | (32'(mb[b + i]) << (8 * i));
    if (f == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
    if (f == 3'b001 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
      check("rdata", rdata, exp_rdata);
      if (lit_req != lit_done) begin
        check({"lit_", lit_name}, rdata, lit_exp);
        check({"model_", lit_name}, exp_rdata, lit_exp);
        lit_done = lit_req;
      end
    end
  end

  task automatic lit(input string n, input logic [31:0] v);
    lit_name = n;
    lit_exp  = v;
    lit_req++;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
    bit m;
    mem_read_en  = rd;
    mem_write_en = wr;
    funct3       = f;
    addr         = a;
    wdata        = d;
    exp_stall    = 1'b1;
    repeat (LATENCY) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    m = is_mis(f, a);
    if (wr) begin
      if (!m) m_store(f, a, d);
    end else begin
      exp_rdata = m ? 32'h0 : m_load(f, a);
    end
    exp_stall    = 1'b0;
    exp_mis      = m;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    @(posedge clk);
    #1;
    exp_mis = 1'b0;
  endtask

  task automatic reset_in_wait(input logic [31:0] a, input logic [31:0] d);
    mem_write_en = 1'b1;
    funct3       = 3'b010;
    addr         = a;
    wdata        = d;
    exp_stall    = 1'b1;
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    mem_write_en = 1'b0;
    exp_stall    = 1'b0;
    exp_rdata    = '0;
    exp_mis      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lit("reset_rdata", 32'h0);

    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    access(1, 0, 3'b010, 32'h10, 32'h0);
    lit("lw_10", 32'hDEADBEEF);

    access(0, 1, 3'b000, 32'h13, 32'hFFFFFFA5);
    access(1, 0, 3'b010, 32'h10, 32'h0);
    lit("lw_after_sb", 32'hA5ADBEEF);
    access(1, 0, 3'b000, 32'h13, 32'h0);
    lit("lb_13", 32'hFFFFFFA5);
    access(1, 0, 3'b100, 32'h13, 32'h0);
    lit("lbu_13", 32'h000000A5);
    access(1, 0, 3'b001, 32'h12, 32'h0);
    lit("lh_12", 32'hFFFFA5AD);
    access(1, 0, 3'b101, 32'h12, 32'h0);
    lit("lhu_12", 32'h0000A5AD);

    access(0, 1, 3'b010, 32'h20, 32'h0);
    reset_in_wait(32'h20, 32'h12345678);
    lit("rdata_after_reset", 32'h0);
    access(1, 0, 3'b010, 32'h20, 32'h0);
    lit("lw_20_dropped", 32'h0);

    access(0, 1, 3'b010, 32'h400, 32'h11111111);
    access(1, 0, 3'b010, 32'h0, 32'h0);
    lit("lw_wrap", 32'h11111111);

    access(1, 0, 3'b010, 32'h12, 32'h0);
    lit("lw_12_misaligned", MCHK ? 32'h0 : 32'hA5ADBEEF);

    access(1, 1, 3'b010, 32'h30, 32'hCAFEF00D);
    lit("both_hold", MCHK ? 32'h0 : 32'hA5ADBEEF);
    access(1, 0, 3'b010, 32'h30, 32'h0);
    lit("lw_30", 32'hCAFEF00D);

    access(0, 1, 3'b010, 32'h14, 32'h0);
    access(0, 1, 3'b001, 32'h16, 32'h56781234);
    access(1, 0, 3'b010, 32'h14, 32'h0);
    lit("lw_after_sh", 32'h12340000);
    access(1, 0, 3'b001, 32'h16, 32'h0);
    lit("lh_16", 32'h00001234);

    access(1, 0, 3'b011, 32'h10, 32'h0);
    lit("f3_011_as_word", 32'hA5ADBEEF);

    access(0, 1, 3'b000, 32'h14, 32'h0000007F);
    access(1, 0, 3'b000, 32'h14, 32'h0);
    lit("lb_positive", 32'h0000007F);
    access(1, 0, 3'b010, 32'h14, 32'h0);
    lit("lw_after_sb_14", 32'h1234007F);

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
